config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader_if.sv | 25 ++
 rtl/config_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/config_loader_if.sv
// rtl/config_loader_if.sv - serial config stream and cluster write bus for config_loader
interface config_loader_if #(
  parameter int NUM_CLUSTERS = 8,
  parameter int CFG_W        = 16
);
  logic                    config_in;
  logic                    config_vld;
  logic                    err_clr;
  logic                    cfg_we;
  logic [7:0]              cfg_addr;
  logic [CFG_W-1:0]        cfg_data;
  logic [NUM_CLUSTERS-1:0] cfg_loaded;
  logic                    all_loaded;
  logic                    cfg_err;

  modport master (
    output config_in, config_vld, err_clr,
    input  cfg_we, cfg_addr, cfg_data, cfg_loaded, all_loaded, cfg_err
  );

  modport slave (
    input  config_in, config_vld, err_clr,
    output cfg_we, cfg_addr, cfg_data, cfg_loaded, all_loaded, cfg_err
  );
endinterface

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial frame parser writing per-cluster config; CFG_CHECKSUM_EN adds a checksum byte
module config_loader #(
  parameter int          NUM_CLUSTERS = 8,
  parameter int          CFG_W        = 16,
  parameter logic [7:0]  SYNC         = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  config_loader_if.slave bus
);

  typedef enum logic [2:0] {
    HUNT,
    ADDR,
    DATA,
`ifdef CFG_CHECKSUM_EN
    CHECK,
`endif
    COMMIT
  } state_t;

  localparam logic [6:0]  DATA_LAST = 7'(CFG_W - 1);
  localparam logic [31:0] NC_U      = NUM_CLUSTERS;

  state_t                  r_state;
  logic [7:0]              r_win;
  logic [7:0]              r_addr;
  logic [CFG_W-1:0]        r_data;
  logic [6:0]              r_cnt;
  logic                    r_we;
  logic [7:0]              r_cfg_addr;
  logic [CFG_W-1:0]        r_cfg_data;
  logic [NUM_CLUSTERS-1:0] r_loaded;
  logic                    r_err;

  logic                    w_bit;
  logic                    w_vld;
  logic [7:0]              w_win_next;
  logic [7:0]              w_addr_next;
  logic [CFG_W-1:0]        w_data_next;
  logic                    w_addr_bad;
  logic [NUM_CLUSTERS-1:0] w_hot;

  assign w_bit       = bus.config_in;
  assign w_vld       = bus.config_vld;
  assign w_win_next  = {r_win[6:0], w_bit};
  assign w_addr_next = {r_addr[6:0], w_bit};
  assign w_data_next = {r_data[CFG_W-2:0], w_bit};
  assign w_addr_bad  = ({24'd0, r_addr} >= NC_U);

  // One-hot of the received address, used to mark the cluster as loaded
  always_comb begin
    w_hot = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      w_hot[i] = (r_addr == 8'(i));
    end
  end

`ifdef CFG_CHECKSUM_EN
  localparam int NB = CFG_W / 8;

  logic [7:0] r_ck;
  logic [7:0] w_ck_next;
  logic [7:0] w_csum;

  assign w_ck_next = {r_ck[6:0], w_bit};

  // Expected checksum: XOR of the address byte and every payload byte
  always_comb begin
    w_csum = r_addr;
    for (int i = 0; i < NB; i++) begin
      w_csum = w_csum ^ r_data[i*8 +: 8];
    end
  end
`endif

  // Frame parser FSM with registered write strobe, hold registers, loaded map and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_win      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_we       <= 1'b0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_loaded   <= '0;
      r_err      <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      r_ck       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      // A new error later in this block overrides a simultaneous clear
      if (bus.err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        HUNT: begin
          if (w_vld) begin
            if (w_win_next == SYNC) begin
              r_state <= ADDR;
              r_win   <= '0;
              r_cnt   <= '0;
            end else begin
              r_win <= w_win_next;
            end
          end
        end
        ADDR: begin
          if (w_vld) begin
            r_addr <= w_addr_next;
            if (r_cnt == 7'd7) begin
              r_cnt   <= '0;
              r_state <= DATA;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end
        DATA: begin
          if (w_vld) begin
            r_data <= w_data_next;
            if (r_cnt == DATA_LAST) begin
              r_cnt <= '0;
`ifdef CFG_CHECKSUM_EN
              r_state <= CHECK;
`else
              if (w_addr_bad) begin
                r_err   <= 1'b1;
                r_state <= HUNT;
              end else begin
                r_we       <= 1'b1;
                r_cfg_addr <= r_addr;
                r_cfg_data <= w_data_next;
                r_loaded   <= r_loaded | w_hot;
                r_state    <= COMMIT;
              end
`endif
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end
`ifdef CFG_CHECKSUM_EN
        CHECK: begin
          if (w_vld) begin
            r_ck <= w_ck_next;
            if (r_cnt == 7'd7) begin
              r_cnt <= '0;
              if (w_addr_bad || (w_ck_next != w_csum)) begin
                r_err   <= 1'b1;
                r_state <= HUNT;
              end else begin
                r_we       <= 1'b1;
                r_cfg_addr <= r_addr;
                r_cfg_data <= r_data;
                r_loaded   <= r_loaded | w_hot;
                r_state    <= COMMIT;
              end
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
        end
`endif
        COMMIT: begin
          // Any bit offered in this cycle is intentionally ignored
          r_state <= HUNT;
          r_win   <= '0;
        end
        default: begin
          r_state <= HUNT;
          r_win   <= '0;
        end
      endcase
    end
  end

  assign bus.cfg_we     = r_we;
  assign bus.cfg_addr   = r_cfg_addr;
  assign bus.cfg_data   = r_cfg_data;
  assign bus.cfg_loaded = r_loaded;
  assign bus.all_loaded = &r_loaded;
  assign bus.cfg_err    = r_err;

endmodule
